// File: rtl/regfile_scoreboard.sv
// Dual-issue hazard scoreboard for a 2-write / 4-read register file: RAW, WAW, intra-pair and write-port checks.
// Optional build macro SCOREBOARD_STATS_EN adds dual-issue and slot-1 stall counters (dual_cnt, stall_cnt).

module regfile_scoreboard #(
    parameter int NREGS  = 32,
    parameter int MAXLAT = 4,
    parameter int CW     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       valid_1,
    input  logic                       valid_2,
    input  logic [$clog2(NREGS)-1:0]   rs1_1,
    input  logic [$clog2(NREGS)-1:0]   rs2_1,
    input  logic [$clog2(NREGS)-1:0]   rs1_2,
    input  logic [$clog2(NREGS)-1:0]   rs2_2,
    input  logic [$clog2(NREGS)-1:0]   rd_1,
    input  logic [$clog2(NREGS)-1:0]   rd_2,
    input  logic                       wr_1,
    input  logic                       wr_2,
    input  logic [1:0]                 lat_1,
    input  logic [1:0]                 lat_2,
    output logic                       issue_1,
    output logic                       issue_2,
    output logic [NREGS-1:0]           busy
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                dual_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    logic [CW-1:0]    cnt_q [NREGS];
    logic [CW-1:0]    cnt_d [NREGS];
    logic [1:0]       wbq_q [1:MAXLAT];
    logic [1:0]       wbq_d [1:MAXLAT];
    logic [1:0]       wbq_s [1:MAXLAT];
    logic [NREGS-1:0] rdy;
    logic [CW-1:0]    lat1;
    logic [CW-1:0]    lat2;
    logic             nwb_1;
    logic             nwb_2;
    logic [2:0]       occ_1;
    logic [2:0]       occ_2;

    assign lat1  = CW'(lat_1) + CW'(1);
    assign lat2  = CW'(lat_2) + CW'(1);
    assign nwb_1 = wr_1 && (rd_1 != '0);
    assign nwb_2 = wr_2 && (rd_2 != '0);

    // A count of 1 means the write lands this cycle and is bypassed, so the source is already usable.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        rdy  = '0;
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            rdy[r]  = (r == 0) || (cnt_q[r] <= CW'(1));
            busy[r] = (cnt_q[r] > CW'(1));
        end
    end

    // Queue as it will look after this edge's shift; wbq_s[L] counts writes landing in the same cycle as a new latency-L op.
    always_comb begin
        for (int k = 1; k < MAXLAT; k++) begin
            wbq_s[k] = wbq_q[k+1];
        end
        wbq_s[MAXLAT] = '0;
    end

    always_comb begin
        occ_1 = {1'b0, wbq_s[lat1]} + {2'b00, nwb_1};
        occ_2 = {1'b0, wbq_s[lat2]} + {2'b00, nwb_2} + {2'b00, (nwb_1 && (lat1 == lat2))};

        issue_1 = rst && valid_1 && !flush
               && rdy[rs1_1] && rdy[rs2_1]
               && !(nwb_1 && (cnt_q[rd_1] > lat1))
               && (occ_1 <= 3'd2);

        issue_2 = issue_1 && valid_2
               && rdy[rs1_2] && rdy[rs2_2]
               && !(nwb_2 && (cnt_q[rd_2] > lat2))
               && !(nwb_1 && ((rs1_2 == rd_1) || (rs2_2 == rd_1)))
               && !(nwb_1 && nwb_2 && (rd_1 == rd_2))
               && (occ_2 <= 3'd2);
    end

    // Loads are applied after the decrement so a new issue overrides the old countdown; flush overrides both.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CW'(1)) : '0;
        end
        for (int k = 1; k <= MAXLAT; k++) begin
            wbq_d[k] = wbq_s[k];
        end
        if (issue_1 && nwb_1) begin
            cnt_d[rd_1] = lat1;
            wbq_d[lat1] = wbq_d[lat1] + 2'd1;
        end
        if (issue_2 && nwb_2) begin
            cnt_d[rd_2] = lat2;
            wbq_d[lat2] = wbq_d[lat2] + 2'd1;
        end
        if (flush) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_d[r] = '0;
            end
            for (int k = 1; k <= MAXLAT; k++) begin
                wbq_d[k] = '0;
            end
        end
    end

    // NOTE: these arrays are individual flops rather than a RAM, so they take the async reset like any register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            for (int k = 1; k <= MAXLAT; k++) begin
                wbq_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of its neighbours.
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            for (int k = 1; k <= MAXLAT; k++) begin
                wbq_q[k] <= wbq_d[k];
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] dual_q;
    logic [31:0] stall_q;

    // Statistics survive flush; only reset clears them, and they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dual_q  <= '0;
            stall_q <= '0;
        end else begin
            if (issue_1 && issue_2) begin
                dual_q <= dual_q + 32'd1;
            end
            if (valid_1 && !issue_1) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign dual_cnt  = dual_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: an absolute-time reference model predicts issue bits and busy each cycle.
module tb_regfile_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] lat;
    } ins_t;

    typedef struct packed {
        logic        i1;
        logic        i2;
        logic [31:0] busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        valid_1 = 1'b0, valid_2 = 1'b0;
    logic [4:0]  rs1_1 = '0, rs2_1 = '0, rs1_2 = '0, rs2_2 = '0, rd_1 = '0, rd_2 = '0;
    logic        wr_1 = 1'b0, wr_2 = 1'b0;
    logic [1:0]  lat_1 = '0, lat_2 = '0;
    logic        issue_1, issue_2;
    logic [31:0] busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] dual_cnt, stall_cnt;
`endif

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_1(valid_1), .valid_2(valid_2),
        .rs1_1(rs1_1), .rs2_1(rs2_1), .rs1_2(rs1_2), .rs2_2(rs2_2),
        .rd_1(rd_1), .rd_2(rd_2), .wr_1(wr_1), .wr_2(wr_2),
        .lat_1(lat_1), .lat_2(lat_2),
        .issue_1(issue_1), .issue_2(issue_2), .busy(busy)
`ifdef SCOREBOARD_STATS_EN
        , .dual_cnt(dual_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t expq[$];

    // Reference model: absolute cycle at which each register's pending write lands, and writes per landing cycle.
    int t = 0;
    int land [32];
    int lands [int];
    int unsigned m_dual = 0, m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) land[r] = -100;
        lands.delete();
    endfunction

    function automatic bit src_ok(input logic [4:0] a);
        return (a == 0) || (land[a] <= t);
    endfunction

    function automatic int occ(input int c);
        return lands.exists(c) ? lands[c] : 0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] bz = '0;
        for (int r = 1; r < 32; r++) bz[r] = (land[r] > t);
        return bz;
    endfunction

    function automatic void model_issue(input ins_t a, input ins_t b, input logic fl,
                                        output logic e1, output logic e2);
        int  l1 = int'(a.lat) + 1;
        int  l2 = int'(b.lat) + 1;
        bit  w1 = a.wr && (a.rd != 0);
        bit  w2 = b.wr && (b.rd != 0);
        e1 = a.v && !fl && src_ok(a.rs1) && src_ok(a.rs2)
          && !(w1 && land[a.rd] >= t + l1)
          && (occ(t + l1) + int'(w1) <= 2);
        e2 = e1 && b.v && src_ok(b.rs1) && src_ok(b.rs2)
          && !(w2 && land[b.rd] >= t + l2)
          && !(w1 && (b.rs1 == a.rd || b.rs2 == a.rd))
          && !(w1 && w2 && a.rd == b.rd)
          && (occ(t + l2) + int'(w2) + int'(w1 && l1 == l2) <= 2);
    endfunction

    function automatic void model_commit(input ins_t a, input ins_t b, input logic fl,
                                         input logic e1, input logic e2);
        int l1 = int'(a.lat) + 1;
        int l2 = int'(b.lat) + 1;
        if (e1 && e2) m_dual++;
        if (a.v && !e1) m_stall++;
        if (fl) begin
            model_reset();
        end else begin
            if (e1 && a.wr && a.rd != 0) begin
                land[a.rd] = t + l1;
                lands[t + l1] = occ(t + l1) + 1;
            end
            if (e2 && b.wr && b.rd != 0) begin
                land[b.rd] = t + l2;
                lands[t + l2] = occ(t + l2) + 1;
            end
        end
        t++;
    endfunction

    function automatic ins_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic wr, input int lat);
        ins_t i;
        i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd); i.wr = wr; i.lat = 2'(lat);
        return i;
    endfunction

    function automatic ins_t rnd();
        return mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 4) != 0, $urandom_range(0, 3));
    endfunction

    // Driver: apply one cycle of stimulus at the falling edge, push the prediction, advance the model.
    task automatic step(input ins_t a, input ins_t b, input logic fl, output logic e1, output logic e2);
        exp_t e;
        @(negedge clk);
        valid_1 = a.v; rs1_1 = a.rs1; rs2_1 = a.rs2; rd_1 = a.rd; wr_1 = a.wr; lat_1 = a.lat;
        valid_2 = b.v; rs1_2 = b.rs1; rs2_2 = b.rs2; rd_2 = b.rd; wr_2 = b.wr; lat_2 = b.lat;
        flush = fl;
        model_issue(a, b, fl, e1, e2);
        e.i1 = e1; e.i2 = e2; e.busy = model_busy();
        expq.push_back(e);
        model_commit(a, b, fl, e1, e2);
        #3;
    endtask

    // Monitor: compares DUT outputs against the oldest prediction, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("sb_issue_1", 32'(issue_1), 32'(e.i1));
                check("sb_issue_2", 32'(issue_2), 32'(e.i2));
                check("sb_busy", busy, e.busy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        logic e1, e2;
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, e1, e2);
    endtask

    task automatic reset_pulse();
        valid_1 = 1'b1; rs1_1 = '0; rs2_1 = '0; wr_1 = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_busy_clear", busy, 32'h0);
        check("rst_issue_1_low", 32'(issue_1), 32'h0);
        model_reset();
        m_dual = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b1;
        valid_1 = 1'b0; valid_2 = 1'b0; flush = 1'b0;
    endtask

    ins_t a, b;
    logic e1, e2;
    int   cnt;

    initial begin
        model_reset();
        valid_1 = 1'b1;
        #2;
        check("reset_busy", busy, 32'h0);
        check("reset_issue_1", 32'(issue_1), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        valid_1 = 1'b0;

        // Independent pair
        step(mk(1, 1, 2, 5, 1, 0), mk(1, 3, 4, 6, 1, 0), 1'b0, e1, e2);
        check("pair_issue_1", 32'(issue_1), 32'h1);
        check("pair_issue_2", 32'(issue_2), 32'h1);
        idle_cycles(1);
        check("pair_busy_5_6", 32'(busy[6:5]), 32'h0);

        // Long-latency RAW
        step(mk(1, 0, 0, 7, 1, 3), '0, 1'b0, e1, e2);
        for (int k = 1; k <= 3; k++) begin
            step(mk(1, 7, 0, 11, 1, 0), '0, 1'b0, e1, e2);
            check("raw_stall", 32'(issue_1), 32'h0);
        end
        step(mk(1, 7, 0, 11, 1, 0), '0, 1'b0, e1, e2);
        check("raw_release", 32'(issue_1), 32'h1);
        idle_cycles(4);

        // Intra-pair dependency, then replay the slot-2 op in slot 1
        step(mk(1, 0, 0, 3, 1, 1), mk(1, 0, 3, 13, 1, 0), 1'b0, e1, e2);
        check("intra_issue_1", 32'(issue_1), 32'h1);
        check("intra_issue_2", 32'(issue_2), 32'h0);
        cnt = 0;
        e1 = 1'b0;
        while (!e1 && cnt < 6) begin
            step(mk(1, 0, 3, 13, 1, 0), '0, 1'b0, e1, e2);
            cnt++;
        end
        check("intra_replay_issued", 32'(issue_1), 32'h1);
        check("intra_replay_wait", 32'(cnt), 32'd2);
        idle_cycles(4);

        // Write-port conflict
        step(mk(1, 0, 0, 8, 1, 2), '0, 1'b0, e1, e2);
        idle_cycles(1);
        step(mk(1, 0, 0, 9, 1, 0), mk(1, 0, 0, 10, 1, 0), 1'b0, e1, e2);
        check("port_issue_1", 32'(issue_1), 32'h1);
        check("port_issue_2", 32'(issue_2), 32'h0);
        idle_cycles(4);

        // WAW stall, then reg 0 writes
        step(mk(1, 0, 0, 4, 1, 3), '0, 1'b0, e1, e2);
        cnt = 0;
        e1 = 1'b0;
        while (cnt < 8) begin
            step(mk(1, 0, 0, 4, 1, 0), '0, 1'b0, e1, e2);
            if (issue_1) break;
            cnt++;
        end
        check("waw_stall_cycles", 32'(cnt), 32'd3);
        step(mk(1, 0, 0, 0, 1, 3), mk(1, 0, 0, 0, 1, 3), 1'b0, e1, e2);
        check("reg0_issue_1", 32'(issue_1), 32'h1);
        check("reg0_issue_2", 32'(issue_2), 32'h1);
        idle_cycles(1);
        check("reg0_busy", busy, 32'h0);
        idle_cycles(4);

        // Flush
        step(mk(1, 0, 0, 12, 1, 3), '0, 1'b0, e1, e2);
        step(mk(1, 1, 2, 14, 1, 0), mk(1, 1, 2, 15, 1, 0), 1'b1, e1, e2);
        check("flush_issue_1", 32'(issue_1), 32'h0);
        check("flush_issue_2", 32'(issue_2), 32'h0);
        idle_cycles(1);
        check("flush_busy", busy, 32'h0);

        // Asynchronous reset mid-countdown
        step(mk(1, 0, 0, 14, 1, 3), '0, 1'b0, e1, e2);
        check("pre_rst_busy14", 32'(busy[14]), 32'h0);
        idle_cycles(1);
        check("countdown_busy14", 32'(busy[14]), 32'h1);
        reset_pulse();

        // Randomized traffic with occasional flushes and one mid-run reset
        for (int n = 0; n < 600; n++) begin
            a = rnd();
            b = rnd();
            step(a, b, ($urandom_range(0, 29) == 0), e1, e2);
            if (n == 300) reset_pulse();
        end
        idle_cycles(2);

`ifdef SCOREBOARD_STATS_EN
        check("stats_dual", dual_cnt, m_dual);
        check("stats_stall", stall_cnt, m_stall);
`endif
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
